// File: rtl/display_reloj.sv
// Multiplexed 4-digit common-anode 7-segment driver with per-frame time snapshot and per-slot blanking.
// Optional macro DISPLAY_BLINK_EN: colon (hour-units decimal point) follows the synchronized segundo input.
module display_reloj #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       segundo,
    input  logic [3:0] Umin,
    input  logic [3:0] Dmin,
    input  logic [3:0] hora,
    output logic [3:0] anodo,
    output logic [6:0] segmentos,
    output logic       punto
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST_C  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] enc_digit(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    umin_q, dmin_q, hora_q;
    logic [3:0]    anodo_q, anodo_d;
    logic [6:0]    seg_q, seg_d;
    logic          punto_q, punto_d;
    logic          frame_end_s, in_blank_s, colon_s;
    logic [6:0]    hr_tens_s, hr_units_s, glyph_s;

    assign frame_end_s = (idx_q == 2'd3) && (cnt_q == LAST_C);

    generate
        if (BLANK > 0) begin : g_blank
            assign in_blank_s = (cnt_q < BLANK_C);
        end else begin : g_noblank
            assign in_blank_s = 1'b0;
        end
    endgenerate

`ifdef DISPLAY_BLINK_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for the asynchronous seconds wave
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], segundo};
        end
    end

    assign colon_s = ~sync_q[1];
`else
    logic unused_segundo_s;
    assign unused_segundo_s = segundo;
    assign colon_s = 1'b0;
`endif

    // Slot counter and digit index advance
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == LAST_C) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // Hour split into tens/units glyphs; tens is blanked for single-digit hours
    always_comb begin
        hr_tens_s  = SEG_DASH;
        hr_units_s = SEG_DASH;
        if ((hora_q >= 4'd1) && (hora_q <= 4'd9)) begin
            hr_tens_s  = SEG_BLANK;
            hr_units_s = enc_digit(hora_q);
        end else if ((hora_q >= 4'd10) && (hora_q <= 4'd12)) begin
            hr_tens_s  = enc_digit(4'd1);
            hr_units_s = enc_digit(hora_q - 4'd10);
        end else begin
            hr_tens_s  = SEG_DASH;
            hr_units_s = SEG_DASH;
        end
    end

    // Glyph selection and next output values
    always_comb begin
        case (idx_q)
            2'd0:    glyph_s = enc_digit(umin_q);
            2'd1:    glyph_s = enc_digit(dmin_q);
            2'd2:    glyph_s = hr_units_s;
            2'd3:    glyph_s = hr_tens_s;
            default: glyph_s = SEG_DASH;
        endcase
        anodo_d = 4'b1111;
        seg_d   = SEG_BLANK;
        punto_d = 1'b1;
        if (!in_blank_s) begin
            anodo_d = ~(4'b0001 << idx_q);
            seg_d   = glyph_s;
            punto_d = (idx_q == 2'd2) ? colon_s : 1'b1;
        end else begin
            anodo_d = 4'b1111;
        end
    end

    // Scan state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            anodo_q <= 4'b1111;
            seg_q   <= SEG_BLANK;
            punto_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anodo_q <= anodo_d;
            seg_q   <= seg_d;
            punto_q <= punto_d;
        end
    end

    // Time snapshot: reloaded at frame end so a frame never shows a torn time
    always_ff @(posedge clock) begin
        if (reset || frame_end_s) begin
            umin_q <= Umin;
            dmin_q <= Dmin;
            hora_q <= hora;
        end
    end

    assign anodo     = anodo_q;
    assign segmentos = seg_q;
    assign punto     = punto_q;
endmodule

// File: tb/tb_display_reloj.sv
// Self-checking bench for display_reloj at DIV=8, BLANK=2: frame-level model plus hand-computed spot checks.
module tb_display_reloj;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;
    localparam logic [6:0] DIGITS [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                           7'b0000000, 7'b0010000};

    logic       clock = 1'b0;
    logic       reset, segundo;
    logic [3:0] Umin, Dmin, hora;
    logic [3:0] anodo;
    logic [6:0] segmentos;
    logic       punto;

    int checks = 0;
    int errors = 0;

    display_reloj #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clock(clock), .reset(reset), .segundo(segundo),
        .Umin(Umin), .Dmin(Dmin), .hora(hora),
        .anodo(anodo), .segmentos(segmentos), .punto(punto)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: edges since reset release, per-frame snapshot of the inputs, seconds delay line
    int         edges = 0;
    logic       started = 1'b0;
    int         su [0:15];
    int         sd [0:15];
    int         sh [0:15];
    logic       m1, m2, m3;

    always @(posedge clock) begin
        if (reset) begin
            started <= 1'b1;
            edges   <= 0;
            su[0]   <= int'(Umin);
            sd[0]   <= int'(Dmin);
            sh[0]   <= int'(hora);
            m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0;
        end else begin
            edges <= edges + 1;
            if ((edges + 1) % FRAME == 0) begin
                su[((edges + 1) / FRAME) % 16] <= int'(Umin);
                sd[((edges + 1) / FRAME) % 16] <= int'(Dmin);
                sh[((edges + 1) / FRAME) % 16] <= int'(hora);
            end
            m1 <= segundo; m2 <= m1; m3 <= m2;
        end
    end

    function automatic logic [6:0] glyph(input int v);
        if (v < 0) return 7'b1111111;
        if (v > 9) return 7'b0111111;
        return DIGITS[v];
    endfunction

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clock) begin
        if (started) begin
            logic [3:0] ea;
            logic [6:0] es;
            logic       ep;
            int s, f, di, c, h, v;
            ea = 4'b1111; es = 7'b1111111; ep = 1'b1;
            if (edges > 0) begin
                s  = (edges - 1) % FRAME;
                f  = ((edges - 1) / FRAME) % 16;
                di = s / DIV;
                c  = s % DIV;
                if (c >= BLANK) begin
                    h = sh[f];
                    case (di)
                        0: v = su[f];
                        1: v = sd[f];
                        2: v = (h >= 1 && h <= 12) ? h % 10 : 15;
                        default: v = (h >= 10 && h <= 12) ? 1 : ((h >= 1 && h <= 9) ? -1 : 15);
                    endcase
                    ea = 4'b1111;
                    ea[di] = 1'b0;
                    es = glyph(v);
`ifdef DISPLAY_BLINK_EN
                    ep = (di == 2) ? ~m3 : 1'b1;
`else
                    ep = (di == 2) ? 1'b0 : 1'b1;
`endif
                end
            end
            chk("model_anodo", {28'd0, anodo}, {28'd0, ea});
            chk("model_seg", {25'd0, segmentos}, {25'd0, es});
            chk("model_punto", {31'd0, punto}, {31'd0, ep});
        end
    end

    task automatic go(input int e);
        int n = 0;
        while (edges != e && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("reach_edge", edges, e);
    endtask

    task automatic spot(input string name, input logic [3:0] a, input logic [6:0] s);
        chk({name, "_anodo"}, {28'd0, anodo}, {28'd0, a});
        chk({name, "_seg"}, {25'd0, segmentos}, {25'd0, s});
    endtask

    initial begin
        reset = 1'b1; segundo = 1'b0;
        hora = 4'd12; Dmin = 4'd3; Umin = 4'd4;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_anodo", {28'd0, anodo}, 32'h0000000F);
        chk("reset_punto", {31'd0, punto}, 32'd1);
        reset = 1'b0;
        go(2);   spot("blank_win", 4'b1111, 7'b1111111);
        go(3);   spot("idx0_umin", 4'b1110, 7'b0011001);
        chk("idx0_punto", {31'd0, punto}, 32'd1);
        go(11);  spot("idx1_dmin", 4'b1101, 7'b0110000);
        go(19);  spot("idx2_hunit", 4'b1011, 7'b0100100);
        go(27);  spot("idx3_htens", 4'b0111, 7'b1111001);
        go(42);  Umin = 4'd5;
        go(67);  spot("snap_new", 4'b1110, 7'b0010010);
        go(70);  hora = 4'd0; Umin = 4'd10;
        go(99);  spot("umin_dash", 4'b1110, 7'b0111111);
        go(115); spot("hunit_dash", 4'b1011, 7'b0111111);
        go(123); spot("htens_dash", 4'b0111, 7'b0111111);
        go(125); hora = 4'd7; Umin = 4'd4;
        go(147); spot("hora7_unit", 4'b1011, 7'b1111000);
        go(155); spot("hora7_tens", 4'b0111, 7'b1111111);
        go(160); segundo = 1'b1;
        go(163); chk("punto_idx0", {31'd0, punto}, 32'd1);
        go(181); chk("punto_idx2_on", {31'd0, punto}, 32'd0);
        go(185); segundo = 1'b0;
        go(213); reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        spot("midreset", 4'b1111, 7'b1111111);
        go(2);   spot("restart_blank", 4'b1111, 7'b1111111);
        go(3);   spot("restart_idx0", 4'b1110, 7'b0011001);
        go(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
